// File: rtl/wb_j1_lsu_if.sv
// Wishbone-style bus between the J1 load/store unit (master) and the system
// fabric (slave). Signal names are taken from the master's point of view.
interface wb_j1_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              cyc_o;
  logic              stb_o;
  logic              we_o;
  logic [ADDR_W-1:0] adr_o;
  logic [DATA_W-1:0] dat_o;
  logic [DATA_W-1:0] dat_i;
  logic              ack_i;
  logic              err_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/wb_j1_lsu.sv
// J1 load/store unit: takes one CPU access at a time and routes it either to
// the Wishbone bus (with ack/err/timeout handling) or to a small UART port
// selected by the top address nibble. All bus/UART outputs are decoded from
// registered state so they drop as soon as reset is asserted.
module wb_j1_lsu #(
  parameter int         DATA_W   = 32,
  parameter int         ADDR_W   = 32,
  parameter logic [3:0] UART_TAG = 4'hF,
  parameter int         TIMEOUT  = 255,
  parameter int         NUM      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_adr_i,
  input  logic [DATA_W-1:0] cpu_dat_i,
  output logic              cpu_busy_o,
  output logic              cpu_done_o,
  output logic              cpu_err_o,
  output logic [DATA_W-1:0] cpu_rdat_o,
  output logic [7:0]        cpu_num,
  wb_j1_lsu_if.master       wb,
  output logic              uart_rd_o,
  output logic              uart_wr_o,
  output logic              uart_adr_o,
  output logic [7:0]        uart_dat_o,
  input  logic [7:0]        uart_dat_i
);

  typedef enum logic [1:0] {IDLE, BUS, UART, RESP} state_t;

  localparam logic [31:0] TIMEOUT_L  = 32'(TIMEOUT);
  localparam bit          TIMEOUT_EN = (TIMEOUT > 0);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              err_q, err_d;

  // State, request latches, wait counter and CPU result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  // Next state plus latch/result updates; err_i beats ack_i, ack_i beats timeout.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          we_d  = cpu_we_i;
          adr_d = cpu_adr_i;
          dat_d = cpu_dat_i;
          cnt_d = '0;
          if (cpu_adr_i[ADDR_W-1 -: 4] == UART_TAG) state_d = UART;
          else                                      state_d = BUS;
        end
      end
      BUS: begin
        if (wb.err_i) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (wb.ack_i) begin
          err_d   = 1'b0;
          state_d = RESP;
          if (!we_q) rdat_d = wb.dat_i;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (TIMEOUT_EN && (cnt_d == TIMEOUT_L)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      UART: begin
        if (!we_q) rdat_d = DATA_W'(uart_dat_i);
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore decode of bus, UART and CPU status outputs from registered state.
  always_comb begin
    wb.cyc_o   = 1'b0;
    wb.stb_o   = 1'b0;
    wb.we_o    = 1'b0;
    wb.adr_o   = '0;
    wb.dat_o   = '0;
    uart_rd_o  = 1'b0;
    uart_wr_o  = 1'b0;
    uart_adr_o = 1'b0;
    uart_dat_o = '0;
    cpu_done_o = 1'b0;
    cpu_busy_o = (state_q != IDLE);
    case (state_q)
      BUS: begin
        wb.cyc_o = 1'b1;
        wb.stb_o = 1'b1;
        wb.we_o  = we_q;
        wb.adr_o = adr_q;
        wb.dat_o = dat_q;
      end
      UART: begin
        uart_rd_o  = !we_q;
        uart_wr_o  = we_q;
        uart_adr_o = adr_q[0];
        uart_dat_o = dat_q[7:0];
      end
      RESP: cpu_done_o = 1'b1;
      default: ;
    endcase
  end

  assign cpu_rdat_o = rdat_q;
  assign cpu_err_o  = err_q;
  assign cpu_num    = 8'(NUM);

endmodule

// File: tb/tb_wb_j1_lsu.sv
// Self-checking bench for wb_j1_lsu: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_wb_j1_lsu;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int TO   = 4;
  localparam int NUMV = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_adr = '0;
  logic [DW-1:0] cpu_dat = '0;
  logic          cpu_busy, cpu_done, cpu_err;
  logic [DW-1:0] cpu_rdat;
  logic [7:0]    cpu_num;
  logic          uart_rd, uart_wr, uart_adr;
  logic [7:0]    uart_dat_o;
  logic [7:0]    uart_dat_i = '0;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_rdat = '0;
  bit          model_err  = 1'b0;

  wb_j1_lsu_if #(.DATA_W(DW), .ADDR_W(AW)) wb_bus ();

  wb_j1_lsu #(
    .DATA_W(DW), .ADDR_W(AW), .UART_TAG(4'hF), .TIMEOUT(TO), .NUM(NUMV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req_i  (cpu_req),
    .cpu_we_i   (cpu_we),
    .cpu_adr_i  (cpu_adr),
    .cpu_dat_i  (cpu_dat),
    .cpu_busy_o (cpu_busy),
    .cpu_done_o (cpu_done),
    .cpu_err_o  (cpu_err),
    .cpu_rdat_o (cpu_rdat),
    .cpu_num    (cpu_num),
    .wb         (wb_bus),
    .uart_rd_o  (uart_rd),
    .uart_wr_o  (uart_wr),
    .uart_adr_o (uart_adr),
    .uart_dat_o (uart_dat_o),
    .uart_dat_i (uart_dat_i)
  );

  always #5 clk = ~clk;

  // Runs one access. delay = BUS cycle index where the slave responds (-1 = never);
  // mode 0 = ack, 1 = err, 2 = ack+err together. Reports what the DUT did.
  task automatic run_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input int delay, input int mode, input logic [7:0] udat,
                         input logic [31:0] rd_data,
                         output int cyc_cnt, output int done_k, output bit err_seen,
                         output logic [31:0] rdat_seen, output int bad_bus,
                         output int urd, output int uwr, output bit uadr,
                         output logic [7:0] uwdat);
    cyc_cnt = 0; done_k = -1; err_seen = 0; rdat_seen = '0; bad_bus = 0;
    urd = 0; uwr = 0; uadr = 0; uwdat = '0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_dat = dat;
    uart_dat_i = udat; wb_bus.dat_i = rd_data; wb_bus.ack_i = 1'b0; wb_bus.err_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k > 0) @(negedge clk);
      if (wb_bus.cyc_o) begin
        cyc_cnt++;
        if (!wb_bus.stb_o || wb_bus.adr_o !== adr || wb_bus.dat_o !== dat || wb_bus.we_o !== we)
          bad_bus++;
      end
      if (uart_rd) urd++;
      if (uart_wr) begin uwr++; uwdat = uart_dat_o; end
      if (uart_rd || uart_wr) uadr = uart_adr;
      if (cpu_done) begin
        done_k = k; err_seen = cpu_err; rdat_seen = cpu_rdat;
        break;
      end
      wb_bus.ack_i = wb_bus.cyc_o && (k == delay) && (mode != 1);
      wb_bus.err_i = wb_bus.cyc_o && (k == delay) && (mode != 0);
    end
    wb_bus.ack_i = 1'b0;
    wb_bus.err_i = 1'b0;
  endtask

  // Transaction-level model: outcome from delay/mode/TIMEOUT with plain arithmetic.
  function automatic void model_txn(input bit we, input bit is_uart, input int delay,
                                    input int mode, input logic [7:0] udat,
                                    input logic [31:0] rd_data,
                                    output int exp_cyc, output int exp_done, output bit exp_err);
    if (is_uart) begin
      exp_cyc = 0; exp_done = 1; exp_err = 0;
      if (!we) model_rdat = {24'h0, udat};
    end else if (delay >= 0 && delay < TO) begin
      exp_cyc = delay + 1; exp_done = delay + 1; exp_err = (mode != 0);
      if (!we && mode == 0) model_rdat = rd_data;
    end else begin
      exp_cyc = TO; exp_done = TO; exp_err = 1;
    end
    model_err = exp_err;
  endfunction

  int          c_cyc, c_done, c_bad, c_urd, c_uwr, e_cyc, e_done;
  bit          c_err, c_uadr, e_err;
  logic [31:0] c_rdat;
  logic [7:0]  c_uwdat;

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({cpu_busy, cpu_done, wb_bus.cyc_o, wb_bus.stb_o, wb_bus.we_o, uart_rd, uart_wr} !== 7'b0 ||
        wb_bus.adr_o !== '0 || wb_bus.dat_o !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: busy=%b done=%b cyc=%b stb=%b we=%b adr=%h dat=%h urd=%b uwr=%b required all 0",
               cpu_busy, cpu_done, wb_bus.cyc_o, wb_bus.stb_o, wb_bus.we_o, wb_bus.adr_o, wb_bus.dat_o, uart_rd, uart_wr);
    end
    checks++;
    if (cpu_rdat !== 32'h0 || cpu_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_result: rdat=%h err=%b required 00000000 0", cpu_rdat, cpu_err);
    end
    checks++;
    if (cpu_num !== 8'(NUMV)) begin
      failures++;
      $display("[TB] FAIL cpu_num: got %0d required %0d", cpu_num, NUMV);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_ack();
    run_txn(0, 32'h10, 32'h0, 0, 0, 8'h00, 32'hDEADBEEF,
            c_cyc, c_done, c_err, c_rdat, c_bad, c_urd, c_uwr, c_uadr, c_uwdat);
    model_txn(0, 0, 0, 0, 8'h00, 32'hDEADBEEF, e_cyc, e_done, e_err);
    checks++;
    if (c_done !== 1) begin
      failures++; $display("[TB] FAIL read_latency: done at %0d required 1", c_done);
    end
    checks++;
    if (c_rdat !== 32'hDEADBEEF || c_err !== 1'b0) begin
      failures++; $display("[TB] FAIL read_data: rdat=%h err=%b required deadbeef 0", c_rdat, c_err);
    end
  endtask

  task automatic test_write_wait();
    run_txn(1, 32'h20, 32'h12345678, 3, 0, 8'h00, 32'hCAFEF00D,
            c_cyc, c_done, c_err, c_rdat, c_bad, c_urd, c_uwr, c_uadr, c_uwdat);
    model_txn(1, 0, 3, 0, 8'h00, 32'hCAFEF00D, e_cyc, e_done, e_err);
    checks++;
    if (c_cyc !== 4 || c_bad !== 0 || c_done !== 4) begin
      failures++;
      $display("[TB] FAIL write_wait: cyc=%0d badbus=%0d done=%0d required 4 0 4", c_cyc, c_bad, c_done);
    end
    checks++;
    if (c_rdat !== 32'hDEADBEEF || c_err !== 1'b0) begin
      failures++; $display("[TB] FAIL write_keeps_rdat: rdat=%h err=%b required deadbeef 0", c_rdat, c_err);
    end
  endtask

  task automatic test_uart_read();
    run_txn(0, 32'hF0000001, 32'h0, -1, 0, 8'h41, 32'h0,
            c_cyc, c_done, c_err, c_rdat, c_bad, c_urd, c_uwr, c_uadr, c_uwdat);
    model_txn(0, 1, -1, 0, 8'h41, 32'h0, e_cyc, e_done, e_err);
    checks++;
    if (c_urd !== 1 || c_uwr !== 0 || c_uadr !== 1'b1 || c_cyc !== 0 || c_done !== 1) begin
      failures++;
      $display("[TB] FAIL uart_read_strobes: rd=%0d wr=%0d adr=%b cyc=%0d done=%0d required 1 0 1 0 1",
               c_urd, c_uwr, c_uadr, c_cyc, c_done);
    end
    checks++;
    if (c_rdat !== 32'h00000041 || c_err !== 1'b0) begin
      failures++; $display("[TB] FAIL uart_read_data: rdat=%h err=%b required 00000041 0", c_rdat, c_err);
    end
  endtask

  task automatic test_timeout();
    run_txn(0, 32'h30, 32'h0, -1, 0, 8'h00, 32'h11111111,
            c_cyc, c_done, c_err, c_rdat, c_bad, c_urd, c_uwr, c_uadr, c_uwdat);
    model_txn(0, 0, -1, 0, 8'h00, 32'h11111111, e_cyc, e_done, e_err);
    checks++;
    if (c_cyc !== TO || c_done !== TO || c_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout: cyc=%0d done=%0d err=%b required %0d %0d 1", c_cyc, c_done, c_err, TO, TO);
    end
    checks++;
    if (c_rdat !== 32'h00000041) begin
      failures++; $display("[TB] FAIL timeout_rdat: rdat=%h required 00000041", c_rdat);
    end
    @(negedge clk);
    checks++;
    if (cpu_err !== 1'b1 || cpu_done !== 1'b0) begin
      failures++; $display("[TB] FAIL err_hold: err=%b done=%b required 1 0", cpu_err, cpu_done);
    end
  endtask

  task automatic test_ack_err();
    run_txn(0, 32'h44, 32'h0, 1, 2, 8'h00, 32'h77777777,
            c_cyc, c_done, c_err, c_rdat, c_bad, c_urd, c_uwr, c_uadr, c_uwdat);
    model_txn(0, 0, 1, 2, 8'h00, 32'h77777777, e_cyc, e_done, e_err);
    checks++;
    if (c_err !== 1'b1 || c_done !== 2 || c_rdat !== 32'h00000041) begin
      failures++;
      $display("[TB] FAIL ack_err_priority: err=%b done=%0d rdat=%h required 1 2 00000041", c_err, c_done, c_rdat);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h40; cpu_dat = '0;
    wb_bus.dat_i = 32'hA5A5A5A5; wb_bus.ack_i = 1'b1; wb_bus.err_i = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_bus.cyc_o !== 1'b1) begin
      failures++; $display("[TB] FAIL b2b_first_cyc: cyc=%b required 1", wb_bus.cyc_o);
    end
    @(negedge clk);
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdat !== 32'hA5A5A5A5) begin
      failures++; $display("[TB] FAIL b2b_first_done: done=%b rdat=%h required 1 a5a5a5a5", cpu_done, cpu_rdat);
    end
    @(negedge clk);
    wb_bus.dat_i = 32'h5A5A0001;
    checks++;
    if (cpu_busy !== 1'b0 || wb_bus.cyc_o !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_idle_gap: busy=%b cyc=%b required 0 0", cpu_busy, wb_bus.cyc_o);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    checks++;
    if (wb_bus.cyc_o !== 1'b1) begin
      failures++; $display("[TB] FAIL b2b_second_cyc: cyc=%b required 1", wb_bus.cyc_o);
    end
    @(negedge clk);
    wb_bus.ack_i = 1'b0;
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdat !== 32'h5A5A0001 || cpu_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_second_done: done=%b rdat=%h err=%b required 1 5a5a0001 0", cpu_done, cpu_rdat, cpu_err);
    end
    model_rdat = 32'h5A5A0001;
    model_err  = 1'b0;
  endtask

  task automatic test_random();
    bit          we, is_uart;
    logic [31:0] adr, dat, rd;
    logic [7:0]  ud;
    int          delay, mode, sel;
    for (int n = 0; n < 30; n++) begin
      we      = 1'($urandom_range(0, 1));
      is_uart = ($urandom_range(0, 3) == 0);
      adr     = $urandom;
      if (is_uart) adr[31:28] = 4'hF;
      else if (adr[31:28] == 4'hF) adr[31:28] = 4'h0;
      dat   = $urandom;
      rd    = $urandom;
      ud    = 8'($urandom);
      delay = $urandom_range(0, 5);
      sel   = $urandom_range(0, 5);
      mode  = (sel < 4) ? 0 : sel - 3;
      run_txn(we, adr, dat, delay, mode, ud, rd,
              c_cyc, c_done, c_err, c_rdat, c_bad, c_urd, c_uwr, c_uadr, c_uwdat);
      model_txn(we, is_uart, delay, mode, ud, rd, e_cyc, e_done, e_err);
      checks++;
      if (c_cyc !== e_cyc || c_done !== e_done || c_bad !== 0) begin
        failures++;
        $display("[TB] FAIL rand_timing[%0d]: cyc=%0d done=%0d badbus=%0d required %0d %0d 0",
                 n, c_cyc, c_done, c_bad, e_cyc, e_done);
      end
      checks++;
      if (c_err !== e_err || c_rdat !== model_rdat) begin
        failures++;
        $display("[TB] FAIL rand_result[%0d]: err=%b rdat=%h required %b %h", n, c_err, c_rdat, e_err, model_rdat);
      end
      checks++;
      if (c_urd !== int'(is_uart && !we) || c_uwr !== int'(is_uart && we) ||
          (is_uart && c_uadr !== adr[0]) || (is_uart && we && c_uwdat !== dat[7:0])) begin
        failures++;
        $display("[TB] FAIL rand_uart[%0d]: rd=%0d wr=%0d adr=%b wdat=%h required %0d %0d %b %h",
                 n, c_urd, c_uwr, c_uadr, c_uwdat, int'(is_uart && !we), int'(is_uart && we), adr[0], dat[7:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h50; cpu_dat = 32'h0BADF00D;
    wb_bus.ack_i = 1'b0; wb_bus.err_i = 1'b0;
    @(negedge clk);
    cpu_req = 1'b0;
    checks++;
    if (wb_bus.cyc_o !== 1'b1) begin
      failures++; $display("[TB] FAIL midrst_pre_cyc: cyc=%b required 1", wb_bus.cyc_o);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (wb_bus.cyc_o !== 1'b0 || wb_bus.stb_o !== 1'b0 || cpu_busy !== 1'b0 || wb_bus.adr_o !== '0) begin
      failures++;
      $display("[TB] FAIL midrst_outputs: cyc=%b stb=%b busy=%b adr=%h required 0 0 0 0",
               wb_bus.cyc_o, wb_bus.stb_o, cpu_busy, wb_bus.adr_o);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (cpu_done || wb_bus.cyc_o) stray++;
    end
    checks++;
    if (stray !== 0 || cpu_rdat !== 32'h0 || cpu_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_after: stray=%0d rdat=%h err=%b required 0 00000000 0", stray, cpu_rdat, cpu_err);
    end
    model_rdat = '0;
    model_err  = 1'b0;
    run_txn(0, 32'h60, 32'h0, 0, 0, 8'h00, 32'h13572468,
            c_cyc, c_done, c_err, c_rdat, c_bad, c_urd, c_uwr, c_uadr, c_uwdat);
    model_txn(0, 0, 0, 0, 8'h00, 32'h13572468, e_cyc, e_done, e_err);
    checks++;
    if (c_done !== e_done || c_rdat !== model_rdat || c_err !== e_err) begin
      failures++;
      $display("[TB] FAIL post_reset_access: done=%0d rdat=%h err=%b required %0d %h %b",
               c_done, c_rdat, c_err, e_done, model_rdat, e_err);
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    wb_bus.dat_i = '0;
    wb_bus.ack_i = 1'b0;
    wb_bus.err_i = 1'b0;
    test_reset();
    test_read_ack();
    test_write_wait();
    test_uart_read();
    test_timeout();
    test_ack_err();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop so a stuck DUT still reports instead of hanging.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
